fpga_gpio_debouncer: RTL and testbench



---
 rtl/fpga_board_pkg.sv | 17 +
 rtl/gpio_debounce_ch.sv | 69 ++++++
 rtl/fpga_gpio_debouncer.sv | 53 +++++
 tb/tb_fpga_gpio_debouncer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_board_pkg.sv
// Shared constants and types for the FPGA board-layer input conditioning.
package fpga_board_pkg;

  localparam int DEFAULT_PRESCALE       = 50000;
  localparam int DEFAULT_STABLE_SAMPLES = 20;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, tick-qualified stable counter,
// debounced level and registered rise/fall pulses.
module gpio_debounce_ch
  import fpga_board_pkg::*;
#(
  parameter int   STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
  parameter logic RESET_BIT      = 1'b0
) (
  input  logic ref_clk,
  input  logic pad_reset,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int           CW       = cnt_width(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          db_nxt, rise_nxt, fall_nxt;
  db_state_e     state;

  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      s1   <= RESET_BIT;
      s2   <= RESET_BIT;
      db   <= RESET_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db   <= db_nxt;
      cnt  <= cnt_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // Any cycle where the synchronised input agrees with db restarts qualification.
  always_comb begin
    state    = (s2 != db) ? ST_PENDING : ST_STABLE;
    cnt_nxt  = cnt;
    db_nxt   = db;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state)
      ST_STABLE: cnt_nxt = '0;
      ST_PENDING: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
            db_nxt   = s2;
            cnt_nxt  = '0;
            rise_nxt = s2;
            fall_nxt = ~s2;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

endmodule

// File: rtl/fpga_gpio_debouncer.sv
// Board switch/button conditioner: shared sample-tick prescaler feeding
// NUM_CH independent debounce channels.
module fpga_gpio_debouncer
  import fpga_board_pkg::*;
#(
  parameter int                NUM_CH         = 12,
  parameter int                PRESCALE       = DEFAULT_PRESCALE,
  parameter int                STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
  parameter logic [NUM_CH-1:0] RESET_VAL      = '0
) (
  input  logic              ref_clk,
  input  logic              pad_reset,
  input  logic [NUM_CH-1:0] gpio_raw_i,
  output logic [NUM_CH-1:0] gpio_db_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              tick_o
);

  localparam int            PW     = cnt_width(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_p, cnt_p_nxt;

  always_comb cnt_p_nxt = (cnt_p == P_LAST) ? '0 : cnt_p + 1'b1;

  // tick_o is registered from the next count so it is high while cnt_p == PRESCALE-1.
  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      cnt_p  <= '0;
      tick_o <= 1'b0;
    end else begin
      cnt_p  <= cnt_p_nxt;
      tick_o <= (cnt_p_nxt == P_LAST);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gpio_debounce_ch #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .RESET_BIT      (RESET_VAL[g])
    ) u_ch (
      .ref_clk   (ref_clk),
      .pad_reset (pad_reset),
      .tick      (tick_o),
      .raw       (gpio_raw_i[g]),
      .db        (gpio_db_o[g]),
      .rise      (rise_o[g]),
      .fall      (fall_o[g])
    );
  end

endmodule

// File: tb/tb_fpga_gpio_debouncer.sv
// Two debouncer configurations driven in lockstep and scored against a
// run-length reference model through per-instance expectation queues.
module tb_fpga_gpio_debouncer;

  localparam int            N   = 12;
  localparam int            P_A = 1;
  localparam int            S_A = 4;
  localparam logic [N-1:0]  R_A = '0;
  localparam int            P_B = 5;
  localparam int            S_B = 3;
  localparam logic [N-1:0]  R_B = '1;

  logic         ref_clk = 1'b0;
  logic         pad_reset;
  logic [N-1:0] raw_a, raw_b, db_a, db_b, rise_a, rise_b, fall_a, fall_b;
  logic         tick_a, tick_b;

  always #5 ref_clk = ~ref_clk;

  fpga_gpio_debouncer #(.NUM_CH(N), .PRESCALE(P_A), .STABLE_SAMPLES(S_A), .RESET_VAL(R_A)) u_dut_a (
    .ref_clk(ref_clk), .pad_reset(pad_reset), .gpio_raw_i(raw_a),
    .gpio_db_o(db_a), .rise_o(rise_a), .fall_o(fall_a), .tick_o(tick_a));

  fpga_gpio_debouncer #(.NUM_CH(N), .PRESCALE(P_B), .STABLE_SAMPLES(S_B), .RESET_VAL(R_B)) u_dut_b (
    .ref_clk(ref_clk), .pad_reset(pad_reset), .gpio_raw_i(raw_b),
    .gpio_db_o(db_b), .rise_o(rise_b), .fall_o(fall_b), .tick_o(tick_b));

  typedef struct {
    int           cyc;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  exp_t q[2][$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: s1/s2 are a two-sample delay of the raw input, k counts
  // edges since reset so the tick is k mod P, run is the number of ticks in a
  // row on which the delayed input disagreed with the debounced level.
  logic [N-1:0] m_s1[2], m_s2[2], m_db[2], m_rise[2], m_fall[2];
  int           m_run[2][N];
  int           m_k[2];

  function automatic int pre(input int c);  return (c == 0) ? P_A : P_B; endfunction
  function automatic int stab(input int c); return (c == 0) ? S_A : S_B; endfunction
  function automatic logic [N-1:0] rval(input int c); return (c == 0) ? R_A : R_B; endfunction
  function automatic logic m_tick(input int c);
    return (m_k[c] >= 1) && ((m_k[c] % pre(c)) == pre(c) - 1);
  endfunction

  task automatic model_edge(input int c, input logic rst, input logic [N-1:0] raw);
    logic tk;
    m_rise[c] = '0;
    m_fall[c] = '0;
    if (rst) begin
      m_s1[c] = rval(c);
      m_s2[c] = rval(c);
      m_db[c] = rval(c);
      m_k[c]  = 0;
      for (int i = 0; i < N; i++) m_run[c][i] = 0;
    end else begin
      tk = m_tick(c);
      for (int i = 0; i < N; i++) begin
        if (m_s2[c][i] == m_db[c][i]) m_run[c][i] = 0;
        else if (tk) begin
          m_run[c][i]++;
          if (m_run[c][i] == stab(c)) begin
            m_db[c][i]  = m_s2[c][i];
            m_run[c][i] = 0;
            if (m_s2[c][i]) m_rise[c][i] = 1'b1;
            else            m_fall[c][i] = 1'b1;
          end
        end
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw;
      m_k[c]++;
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic scoreboard(input int c, input logic [N-1:0] db, input logic tick,
                            input logic [N-1:0] rise, input logic [N-1:0] fall);
    exp_t e;
    check($sformatf("tick_%0d", c), {{(N-1){1'b0}}, tick}, {{(N-1){1'b0}}, m_tick(c)});
    check($sformatf("db_%0d", c), db, m_db[c]);
    if ((m_rise[c] | m_fall[c]) != '0) begin
      e.cyc = cyc; e.rise = m_rise[c]; e.fall = m_fall[c];
      q[c].push_back(e);
    end
    if ((rise | fall) != '0) begin
      if (q[c].size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse_%0d cyc=%0d rise=%h fall=%h expected none", c, cyc, rise, fall);
      end else begin
        e = q[c].pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL pulse_time_%0d actual cyc=%0d expected cyc=%0d", c, cyc, e.cyc);
        end
        check($sformatf("rise_%0d", c), rise, e.rise);
        check($sformatf("fall_%0d", c), fall, e.fall);
      end
    end
    while (q[c].size() != 0 && q[c][0].cyc < cyc) begin
      e = q[c].pop_front();
      checks++; errors++;
      $display("FAIL missing_pulse_%0d cyc=%0d expected rise=%h fall=%h", c, e.cyc, e.rise, e.fall);
    end
  endtask

  // Monitor: inputs seen at a negedge are what the following posedge samples.
  logic         sv_rst;
  logic [N-1:0] sv_a, sv_b;
  initial begin
    #1;
    sv_rst = pad_reset; sv_a = raw_a; sv_b = raw_b;
    forever begin
      @(negedge ref_clk);
      cyc++;
      model_edge(0, sv_rst, sv_a);
      model_edge(1, sv_rst, sv_b);
      scoreboard(0, db_a, tick_a, rise_a, fall_a);
      scoreboard(1, db_b, tick_b, rise_b, fall_b);
      sv_rst = pad_reset; sv_a = raw_a; sv_b = raw_b;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ref_clk);
      #2;
    end
  endtask

  initial begin
    logic pat [8];
    int   n;
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    pad_reset = 1'b1;
    raw_a     = '0;
    raw_b     = '1;
    step(3);
    check("reset_db_a", db_a, R_A);
    check("reset_db_b", db_b, R_B);
    check("reset_pulses", rise_a | fall_a | rise_b | fall_b, '0);
    pad_reset = 1'b0;
    step(10);

    // clean rise, then a bouncing input on bit 3
    raw_a[0] = 1'b1;
    step(10);
    for (int i = 0; i < 8; i++) begin
      raw_a[3] = pat[i];
      step(1);
    end
    step(8);

    // simultaneous multi-channel rise and fall
    raw_a = '0;      step(10);
    raw_a = 12'hA5A; step(10);
    check("multi_rise_level", db_a, 12'hA5A);
    raw_a = '0;      step(10);

    // reset after two qualifying ticks discards the pending change
    raw_a[5] = 1'b1;
    step(4);
    pad_reset = 1'b1; step(2);
    pad_reset = 1'b0; step(12);

    // step latency on the prescaled instance
    raw_b[0] = 1'b0;
    n = 0;
    while (n < 40) begin
      step(1);
      n++;
      if (fall_b[0]) break;
    end
    checks++;
    if (n - 1 < 12 || n - 1 > 17) begin
      errors++;
      $display("FAIL latency_b actual=%0d required 12..17", n - 1);
    end

    // two-tick glitch is rejected
    raw_b[1] = 1'b0; step(10);
    raw_b[1] = 1'b1; step(20);
    check("glitch_b_level", db_b, 12'hFFE);

    repeat (800) begin
      if ($urandom % 6 == 0) raw_a[$urandom % N] ^= 1'b1;
      if ($urandom % 6 == 0) raw_b[$urandom % N] ^= 1'b1;
      pad_reset = ($urandom % 400 == 0);
      step(1);
    end
    pad_reset = 1'b0;
    step(40);

    for (int c = 0; c < 2; c++) begin
      while (q[c].size() != 0) begin
        exp_t e;
        e = q[c].pop_front();
        checks++; errors++;
        $display("FAIL missing_pulse_end_%0d cyc=%0d expected rise=%h fall=%h", c, e.cyc, e.rise, e.fall);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
